uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed-format UART transmitter. It drains bytes from the CSR-fed priority FIFO through the existing rts/next handshake and serialises them on tx. It adds a configurable data width, runtime-selectable parity, one or two stop bits, and back-to-back frames with no idle gap. It sits between the fifo instance and the top-level tx pin.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9); LSB transmitted first.
PRESC_W, 32, width of the prescaler input.

Ports:
clk_i  in  1  system clock.
reset_i  in  1  asynchronous, active-high reset.
prescaler  in  PRESC_W  bit period = prescaler+1 clk_i cycles.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none (reserved).
two_stop  in  1  0 = one stop bit, 1 = two stop bits.
d_in  in  DATA_W  data word from the FIFO head.
rts  in  1  FIFO has data (connected to have_next).
next  out  1  one-cycle pulse; the FIFO pops its head.
tx  out  1  serial line; idle high; registered.
busy  out  1  high from frame load until the last stop bit ends.

Behaviour:
- Reset (async, any state, including mid-frame): tx=1, next=0, busy=0, state=IDLE, counters=0. A partial frame is discarded and no next is issued.
- State machine: IDLE -> START -> DATA -> PARITY (skipped when parity_mode is 00 or 11) -> STOP -> IDLE or START.
- Load, on the edge where state=IDLE and rts=1:
  - capture d_in into the shift register;
  - capture prescaler, parity_mode and two_stop; config changes mid-frame have no effect on the current frame;
  - go to START; registered outputs become tx=0, next=1, busy=1 from that edge on.
- next is high for exactly one cycle per load, never more than once per frame.
- Bit timing: a down-counter reloads to the captured prescaler at every bit boundary. A bit ends when the counter reaches 0, so each bit lasts prescaler+1 cycles; prescaler=0 gives 1 cycle per bit.
- DATA: DATA_W bits, LSB first. The bit index counts 0..DATA_W-1.
- PARITY bit value:
  - even: XOR of the captured data bits;
  - odd: its complement;
  - computed over exactly DATA_W bits.
- STOP: tx=1 for 1 or 2 bit periods.
- End of the final stop bit:
  - if rts=1 on that edge: load immediately (same rules as IDLE load) and go to START with no idle cycle; busy stays 1;
  - else go to IDLE with busy=0.
- Frame length = (1 + DATA_W + P + S) x (prescaler+1) cycles, where P is 0 or 1 and S is 1 or 2.
- rts dropping mid-frame has no effect on the frame in progress.
- rts=1 during reset is ignored. The first load is on the first edge after reset deasserts with rts=1.
- d_in is sampled only on load edges.

Decomposition:
- Package uart_pkg holds:
  - parity_t enum: PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD;
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP;
  - constants UART_MIN_W=5 and UART_MAX_W=9, checked by an elaboration-time assertion on DATA_W.
- Sub-module uart_baud_tick: PRESC_W-bit reloadable down-counter.
  - Inputs: clk_i, reset_i, load, reload value.
  - Output: one-cycle tick at the end of each bit period.
- The bit/stop counters and the FSM stay in uart_tx_cfg.

Test Plan:
- 8N1, prescaler=0, one FIFO write of 'h41 -> tx per cycle after load = 0,1,0,0,0,0,0,1,0,1, then idle 1; one next pulse; busy high for exactly 10 cycles.
- 8E1 / 8O1, prescaler=3, 'h41 -> parity bit 0 (even) or 1 (odd); each bit held 4 cycles; frame = 44 cycles.
- Back-to-back: FIFO filled with 'h41,'h42,'h43, 8N2, prescaler=1 -> three next pulses exactly 22 cycles apart; no tx=1 gap beyond the stop bits; busy continuous for 66 cycles.
- Config change mid-frame: switch parity_mode 00 -> 01 and prescaler 0 -> 5 during DATA of 'h55 -> current frame stays 8N1 at 1 cycle/bit; the next frame uses 8E1 at 6 cycles/bit.
- Reset mid-frame: assert reset_i during data bit 3 of 'h41 -> tx=1, busy=0, next=0 in the same cycle (asynchronously); after release with rts=1, the next FIFO entry is sent from its start bit.
- DATA_W=7, odd parity, 'h7F -> frame is start, seven 1s, parity 0, stop; 10 bits total; the eighth bit is never sent.

Source files
------------

// File: rtl/uart_tx_cfg_pkg.sv
// Shared types and limits for the configurable UART transmitter.
package uart_pkg;

  localparam int UART_MIN_W = 5;
  localparam int UART_MAX_W = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_cfg_baud_tick.sv
// Reloadable down-counter; tick marks the last cycle of each bit period.
module uart_baud_tick #(
  parameter int PRESC_W = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load,
  input  logic [PRESC_W-1:0] reload,
  output logic               tick
);

  logic [PRESC_W-1:0] r_count;

  assign tick = (r_count == '0);

  // A bit lasts reload+1 cycles: the counter restarts from reload when it hits 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (load || tick) begin
      r_count <= reload;
    end else begin
      r_count <= r_count - PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable width, parity and stop bits; drains a
// FIFO through the rts/next handshake and can chain frames without idle gaps.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic [1:0]         parity_mode,
  input  logic               two_stop,
  input  logic [DATA_W-1:0]  d_in,
  input  logic               rts,
  output logic               next,
  output logic               tx,
  output logic               busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  if (DATA_W < UART_MIN_W || DATA_W > UART_MAX_W) begin : g_badWidth
    $error("uart_tx_cfg: DATA_W must lie between UART_MIN_W and UART_MAX_W");
  end

  tx_state_t          r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [IDX_W-1:0]   r_bitIdx;
  logic               r_stopIdx;
  logic [PRESC_W-1:0] r_presc;
  parity_t            r_parMode;
  logic               r_twoStop;
  logic               r_parBit;
  logic               r_tx;
  logic               r_next;
  logic               r_busy;

  tx_state_t          w_stateNext;
  logic [DATA_W-1:0]  w_shiftNext;
  logic [IDX_W-1:0]   w_bitIdxNext;
  logic               w_stopIdxNext;
  logic               w_txNext;
  logic               w_busyNext;
  logic               w_load;
  logic               w_tick;
  logic               w_parEn;
  logic [PRESC_W-1:0] w_reload;

  // A new frame must start its first bit with the live prescaler, not the stale one.
  assign w_reload = w_load ? prescaler : r_presc;
  assign w_parEn  = (r_parMode == PAR_EVEN) || (r_parMode == PAR_ODD);

  uart_baud_tick #(
    .PRESC_W(PRESC_W)
  ) u_baud (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load   (w_load),
    .reload (w_reload),
    .tick   (w_tick)
  );

  always_comb begin
    w_stateNext   = r_state;
    w_shiftNext   = r_shift;
    w_bitIdxNext  = r_bitIdx;
    w_stopIdxNext = r_stopIdx;
    w_txNext      = r_tx;
    w_busyNext    = r_busy;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        w_txNext   = 1'b1;
        w_busyNext = 1'b0;
        if (rts) w_load = 1'b1;
      end
      START: begin
        if (w_tick) begin
          w_stateNext  = DATA;
          w_txNext     = r_shift[0];
          w_shiftNext  = r_shift >> 1;
          w_bitIdxNext = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bitIdx == LAST_IDX) begin
            w_bitIdxNext = '0;
            if (w_parEn) begin
              w_stateNext = PARITY;
              w_txNext    = r_parBit;
            end else begin
              w_stateNext   = STOP;
              w_txNext      = 1'b1;
              w_stopIdxNext = 1'b0;
            end
          end else begin
            w_txNext     = r_shift[0];
            w_shiftNext  = r_shift >> 1;
            w_bitIdxNext = r_bitIdx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_stateNext   = STOP;
          w_txNext      = 1'b1;
          w_stopIdxNext = 1'b0;
        end
      end
      STOP: begin
        // Chaining straight into the next start bit keeps busy high across frames.
        if (w_tick) begin
          if (r_twoStop && !r_stopIdx) begin
            w_stopIdxNext = 1'b1;
          end else if (rts) begin
            w_load = 1'b1;
          end else begin
            w_stateNext   = IDLE;
            w_txNext      = 1'b1;
            w_busyNext    = 1'b0;
            w_stopIdxNext = 1'b0;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_txNext    = 1'b1;
        w_busyNext  = 1'b0;
      end
    endcase
    if (w_load) begin
      w_stateNext   = START;
      w_txNext      = 1'b0;
      w_busyNext    = 1'b1;
      w_shiftNext   = d_in;
      w_bitIdxNext  = '0;
      w_stopIdxNext = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bitIdx  <= '0;
      r_stopIdx <= 1'b0;
      r_presc   <= '0;
      r_parMode <= PAR_NONE;
      r_twoStop <= 1'b0;
      r_parBit  <= 1'b0;
      r_tx      <= 1'b1;
      r_next    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_shift   <= w_shiftNext;
      r_bitIdx  <= w_bitIdxNext;
      r_stopIdx <= w_stopIdxNext;
      r_tx      <= w_txNext;
      r_next    <= w_load;
      r_busy    <= w_busyNext;
      // Frame configuration is frozen here so mid-frame changes wait for the next load.
      if (w_load) begin
        r_presc   <= prescaler;
        r_parMode <= parity_t'(parity_mode);
        r_twoStop <= two_stop;
        r_parBit  <= (^d_in) ^ (parity_mode == PAR_ODD);
      end
    end
  end

  assign tx   = r_tx;
  assign next = r_next;
  assign busy = r_busy;

endmodule
